// File: rtl/bshift_pkg.sv
// bshift_pkg: shared types for the sequential barrel shifter.
package bshift_pkg;
    typedef enum logic [1:0] {MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL} shift_mode_e;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bshift_state_e;
endpackage

// File: rtl/bshift_step.sv
// bshift_step: combinational single-position shift of a word by mode.
module bshift_step
    import bshift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] q
);
    always_comb begin
        q = mode == MODE_LSL ? {d[WIDTH-2:0], 1'b0} :
            mode == MODE_LSR ? {1'b0, d[WIDTH-1:1]} :
            mode == MODE_ASR ? {d[WIDTH-1], d[WIDTH-1:1]} :
                               {d[WIDTH-2:0], d[WIDTH-1]};
    end
endmodule

// File: rtl/seq_barrel_shifter.sv
// seq_barrel_shifter: handshaked multi-cycle shifter, one position per clock.
// Define BSHIFT_DOUBLE_STEP_EN to step two positions per clock while cnt >= 2.
module seq_barrel_shifter
    import bshift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);
    bshift_state_e      state, state_nxt;
    shift_mode_e        mode;
    logic [WIDTH-1:0]   work, step1, step_n;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               accept;

    bshift_step #(.WIDTH(WIDTH)) u_step1 (.d(work), .mode(mode), .q(step1));

`ifdef BSHIFT_DOUBLE_STEP_EN
    logic [WIDTH-1:0] step2;
    logic             two;

    bshift_step #(.WIDTH(WIDTH)) u_step2 (.d(step1), .mode(mode), .q(step2));

    assign two     = cnt > SHAMT_W'(1);
    assign step_n  = two ? step2 : step1;
    assign cnt_nxt = cnt - (two ? SHAMT_W'(2) : SHAMT_W'(1));
`else
    assign step_n  = step1;
    assign cnt_nxt = cnt - SHAMT_W'(1);
`endif

    assign accept    = in_valid && state == S_IDLE;
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign busy      = state == S_SHIFT || state == S_DONE;
    assign out_data  = work;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = in_valid ? (in_shamt == '0 ? S_DONE : S_SHIFT) : S_IDLE;
            S_SHIFT: state_nxt = cnt_nxt == '0 ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = out_ready ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work <= '0;
            mode <= MODE_LSL;
            cnt  <= '0;
        end else if (accept) begin
            work <= in_data;
            mode <= shift_mode_e'(in_mode);
            cnt  <= in_shamt;
        end else if (state == S_SHIFT) begin
            work <= step_n;
            cnt  <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_seq_barrel_shifter.sv
// tb_seq_barrel_shifter: randomized self-checking bench against an arithmetic shift model.
module tb_seq_barrel_shifter;
    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_mode = '0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  out_data;
    int            checks = 0, errors = 0;

    seq_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int n, input logic [1:0] m);
        logic signed [W-1:0] s;
        s = d;
        case (m)
            2'd0:    return d << n;
            2'd1:    return d >> n;
            2'd2:    return s >>> n;
            default: return n == 0 ? d : ((d << n) | (d >> (W - n)));
        endcase
    endfunction

    function automatic int exp_lat(input int n);
`ifdef BSHIFT_DOUBLE_STEP_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [W-1:0] d, input int n, input logic [1:0] m,
                           input logic [W-1:0] exp, input string name);
        int lat;
        out_ready = 1'b1;
        in_data = d; in_shamt = SW'(n); in_mode = m; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept got %b want 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s timeout waiting out_valid", name); end
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL %s data got %h want %h", name, out_data, exp); end
        checks++;
        if (lat != exp_lat(n)) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat(n)); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s after drain out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
            errors++; $display("FAIL reset in_ready/out_valid/busy=%b out_data=%h want 100/00", {in_ready, out_valid, busy}, out_data);
        end
    endtask

    task automatic test_vectors();
        run_cmd(8'hAA, 3, 2'd0, 8'h50, "aa_lsl3");
        run_cmd(8'hAA, 3, 2'd1, 8'h15, "aa_lsr3");
        run_cmd(8'hAA, 3, 2'd2, 8'hF5, "aa_asr3");
        run_cmd(8'hAA, 3, 2'd3, 8'h55, "aa_rol3");
        run_cmd(8'h80, 7, 2'd2, 8'hFF, "80_asr7");
        run_cmd(8'h80, 7, 2'd1, 8'h01, "80_lsr7");
        run_cmd(8'h80, 7, 2'd3, 8'h40, "80_rol7");
        run_cmd(8'h81, 7, 2'd0, 8'h80, "81_lsl7");
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        in_data = 8'hC3; in_shamt = '0; in_mode = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'hC3) begin
            errors++; $display("FAIL zero_amt valid=%b busy=%b data=%h want 1/1/c3", out_valid, busy, out_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_amt_after busy=%b valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] d;
            int n;
            logic [1:0] m;
            d = W'($urandom);
            n = $urandom_range(0, W - 1);
            m = 2'($urandom);
            run_cmd(d, n, m, ref_shift(d, n, m), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_a, exp_b;
        int lat;
        exp_a = ref_shift(8'hAA, 4, 2'd1);
        exp_b = ref_shift(8'h5A, 2, 2'd3);
        out_ready = 1'b0;
        in_data = 8'hAA; in_shamt = 3'd4; in_mode = 2'd1; in_valid = 1'b1;
        tick();
        in_data = 8'h5A; in_shamt = 3'd2; in_mode = 2'd3;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold valid=%b data=%h in_ready=%b want 1/%h/0", out_valid, out_data, in_ready, exp_a);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_b) begin
            errors++; $display("FAIL bp_second valid=%b data=%h want 1/%h", out_valid, out_data, exp_b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        in_data = 8'h3C; in_shamt = 3'd6; in_mode = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre busy=%b valid=%b want 1/0", busy, out_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
            errors++; $display("FAIL rst_mid in_ready/out_valid/busy=%b data=%h want 100/00", {in_ready, out_valid, busy}, out_data);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (out_valid === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d[4];
        int           n[4];
        logic [1:0]   m[4];
        int           idx, got, cycles;
        logic         acc;
        for (int i = 0; i < 4; i++) begin
            d[i] = W'($urandom);
            n[i] = (i == 1) ? 0 : $urandom_range(1, W - 1);
            m[i] = 2'(i);
        end
        out_ready = 1'b1;
        idx = 0; got = 0; cycles = 0;
        while (got < 4 && cycles < 200) begin
            in_valid = idx < 4;
            if (idx < 4) begin in_data = d[idx]; in_shamt = SW'(n[idx]); in_mode = m[idx]; end
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== ref_shift(d[got], n[got], m[got])) begin
                    errors++; $display("FAIL b2b result %0d got %h want %h", got, out_data, ref_shift(d[got], n[got], m[got]));
                end
                got++;
            end
            tick();
            if (acc) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin errors++; $display("FAIL b2b count got %0d want 4", got); end
        tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_zero();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
